// File: rtl/buzzer_tone_generator.sv
// Square-wave buzzer driver: registers the player's note/octave bus, decodes it to a
// half-period count and toggles the speaker at that rate with glitch-free restarts.
module buzzer_tone_generator #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int HALF_W   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [9:0] note_and_pitch,
    output logic       speaker,
    output logic       tone_active,
    output logic       note_onset
);
    typedef enum logic {SILENT, TONE} state_t;

    localparam logic [HALF_W-1:0] ONE    = HALF_W'(1);
    localparam logic [HALF_W-1:0] BASE_C = HALF_W'(CLK_FREQ / (2 * 262));
    localparam logic [HALF_W-1:0] BASE_D = HALF_W'(CLK_FREQ / (2 * 294));
    localparam logic [HALF_W-1:0] BASE_E = HALF_W'(CLK_FREQ / (2 * 330));
    localparam logic [HALF_W-1:0] BASE_F = HALF_W'(CLK_FREQ / (2 * 349));
    localparam logic [HALF_W-1:0] BASE_G = HALF_W'(CLK_FREQ / (2 * 392));
    localparam logic [HALF_W-1:0] BASE_A = HALF_W'(CLK_FREQ / (2 * 440));
    localparam logic [HALF_W-1:0] BASE_B = HALF_W'(CLK_FREQ / (2 * 494));

    logic [9:0]        bus_q;
    logic              en_q;
    logic              note_valid;
    logic [HALF_W-1:0] base_d;
    logic [HALF_W-1:0] half_d;
    logic [5:0]        code_d;
    logic [HALF_W-1:0] half_q;
    logic [5:0]        code_q;
    logic [5:0]        code_prev;
    logic [HALF_W-1:0] counter;
    logic [HALF_W-1:0] counter_next;
    logic              speaker_next;
    logic              onset_next;
    state_t            state;
    state_t            state_next;
    logic              unused_reserved;

    assign unused_reserved = ^bus_q[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q <= '0;
            en_q  <= 1'b0;
        end else begin
            bus_q <= note_and_pitch;
            en_q  <= en;
        end
    end

    always_comb begin
        base_d     = '0;
        note_valid = 1'b1;
        case (bus_q[3:0])
            4'd1:    base_d = BASE_C;
            4'd2:    base_d = BASE_D;
            4'd3:    base_d = BASE_E;
            4'd4:    base_d = BASE_F;
            4'd5:    base_d = BASE_G;
            4'd6:    base_d = BASE_A;
            4'd7:    base_d = BASE_B;
            default: note_valid = 1'b0;
        endcase
    end

    // Rest codes and a disabled input both collapse to code 0 / half-period 0.
    always_comb begin
        code_d = '0;
        half_d = '0;
        if (en_q && note_valid) begin
            code_d = {bus_q[9:8], bus_q[3:0]};
            case (bus_q[9:8])
                2'b00:   half_d = base_d << 1;
                2'b10:   half_d = base_d >> 1;
                default: half_d = base_d;
            endcase
            if (half_d == '0) begin
                half_d = ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= '0;
            half_q <= '0;
        end else begin
            code_q <= code_d;
            half_q <= half_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SILENT;
            counter    <= '0;
            speaker    <= 1'b0;
            note_onset <= 1'b0;
            code_prev  <= '0;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            speaker    <= speaker_next;
            note_onset <= onset_next;
            code_prev  <= code_q;
        end
    end

    // Any code change abandons the current phase, so no runt pulse can leak out.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        speaker_next = speaker;
        onset_next   = 1'b0;
        if (code_q != code_prev) begin
            counter_next = '0;
            speaker_next = 1'b0;
            if (code_q != '0) begin
                state_next = TONE;
                onset_next = 1'b1;
            end else begin
                state_next = SILENT;
            end
        end else begin
            case (state)
                TONE: begin
                    if (counter == half_q - ONE) begin
                        counter_next = '0;
                        speaker_next = ~speaker;
                    end else begin
                        counter_next = counter + ONE;
                    end
                end
                default: begin
                    counter_next = '0;
                    speaker_next = 1'b0;
                end
            endcase
        end
    end

    assign tone_active = (state == TONE);

endmodule
